// File: rtl/pe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_pkg                                                          |
// | Brief    : Shared widths and queue entry layout for the event queue.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pe_pkg;

    localparam int c_code_w = 2;
    localparam int c_ts_w   = 8;

    typedef struct packed {
        logic [c_code_w-1:0] code;
        logic [c_ts_w-1:0]   ts;
    } pe_entry_t;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_fifo_mem                                                     |
// | Brief    : DEPTH-entry register array, one write port, async read port.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pe_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Storage is deliberately unreset; validity is tracked by the count.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : pe_fifo_mem
`default_nettype wire

// File: rtl/priority_event_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : priority_event_queue                                            |
// | Brief    : Edge-detects encoder changes and queues them FIFO with a sticky |
// |            overflow flag. EVENT_TIMESTAMP_EN adds per-entry timestamps.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module priority_event_queue
    import pe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_code_w-1:0] enc_y,
    input  logic                enc_v,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [c_code_w-1:0] out_code,
`ifdef EVENT_TIMESTAMP_EN
    output logic [c_ts_w-1:0]   out_ts,
`endif
    output logic [CW-1:0]       count,
    output logic                overflow,
    input  logic                clr_ovf
);

    localparam int            c_aw   = $clog2(DEPTH);
    localparam logic [CW-1:0] c_full = CW'(DEPTH);
`ifdef EVENT_TIMESTAMP_EN
    localparam int            c_dw   = $bits(pe_entry_t);
`else
    localparam int            c_dw   = c_code_w;
`endif

    logic                r_prev_v;
    logic [c_code_w-1:0] r_prev_y;
    logic [c_aw-1:0]     r_wptr;
    logic [c_aw-1:0]     r_rptr;
    logic [CW-1:0]       r_count;
    logic                r_ovf;

    logic                w_event;
    logic                w_pop;
    logic                w_full;
    logic                w_push;
    logic                w_drop;
    logic [c_dw-1:0]     w_wdata;
    logic [c_dw-1:0]     w_rdata;

    assign w_event = enc_v && (!r_prev_v || (enc_y != r_prev_y));
    assign w_pop   = out_valid && out_ready;
    assign w_full  = (r_count == c_full);
    // A full queue still accepts an event when the head leaves on the same edge.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_v <= 1'b0;
            r_prev_y <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_prev_v <= enc_v;
            r_prev_y <= enc_y;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef EVENT_TIMESTAMP_EN
    logic [c_ts_w-1:0] r_ts;
    pe_entry_t         w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_wdata  = pe_entry_t'{code: enc_y, ts: r_ts};
    assign w_head   = pe_entry_t'(w_rdata);
    assign out_code = out_valid ? w_head.code : '0;
    assign out_ts   = out_valid ? w_head.ts   : '0;
`else
    assign w_wdata  = enc_y;
    assign out_code = out_valid ? w_rdata : '0;
`endif

    pe_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (c_dw),
        .AW    (c_aw)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && !rst),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign overflow  = r_ovf;

endmodule : priority_event_queue
`default_nettype wire

// File: tb/tb_priority_event_queue.sv
`default_nettype none
// Testbench for priority_event_queue: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_priority_event_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enc_v = 1'b0;
    logic [1:0]    enc_y = 2'd0;
    logic          out_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          out_valid;
    logic [1:0]    out_code;
    logic [CW-1:0] count;
    logic          overflow;
`ifdef EVENT_TIMESTAMP_EN
    logic [7:0]    out_ts;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a plain queue of pending entries plus the flags.
    logic [1:0] mq  [$];
    logic [7:0] mts [$];
    logic       m_pv  = 1'b0;
    logic [1:0] m_py  = 2'd0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_tsc = 8'd0;

    logic [6:0] act;
    assign act = {out_valid, count, out_code, overflow};

    always #5 clk = ~clk;

    priority_event_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enc_y     (enc_y),
        .enc_v     (enc_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
`ifdef EVENT_TIMESTAMP_EN
        .out_ts    (out_ts),
`endif
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    function automatic void model_step();
        logic ev, pop, full, drop;
        if (rst) begin
            mq.delete();
            mts.delete();
            m_pv  = 1'b0;
            m_py  = 2'd0;
            m_ovf = 1'b0;
            m_tsc = 8'd0;
        end else begin
            ev   = enc_v && (!m_pv || enc_y != m_py);
            pop  = (mq.size() != 0) && out_ready;
            full = (mq.size() == DEPTH);
            drop = ev && full && !pop;
            if (pop) begin
                void'(mq.pop_front());
                void'(mts.pop_front());
            end
            if (ev && !drop) begin
                mq.push_back(enc_y);
                mts.push_back(m_tsc);
            end
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_pv  = enc_v;
            m_py  = enc_y;
            m_tsc = m_tsc + 8'd1;
        end
    endfunction

    function automatic logic [6:0] exp_state();
        logic [1:0] hc;
        hc = (mq.size() != 0) ? mq[0] : 2'd0;
        return {mq.size() != 0, CW'(mq.size()), hc, m_ovf};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; enc_v = 1'b0; enc_y = 2'd0; out_ready = 1'b0; clr_ovf = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_3102();
        logic [1:0] seq [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
        apply_reset();
        enc_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enc_y = seq[i];
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enc_v = 1'b1; enc_y = 2'd3; out_ready = 1'b1; clr_ovf = 1'b0;
        tick(); tick();
        n_vec++;
        if (act !== 7'd0) begin
            n_err++;
            $display("FAIL reset_state got %b want %b", act, 7'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_event();
        apply_reset();
        enc_v = 1'b1; enc_y = 2'd2;
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if ({out_valid, count, out_code} !== {1'b1, 3'd1, 2'd2}) begin
            n_err++;
            $display("FAIL single_event got v=%0d cnt=%0d code=%0d want v=1 cnt=1 code=2",
                     out_valid, count, out_code);
        end
    endtask

    task automatic test_order();
        logic [1:0] want [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
        fill_3102();
        n_vec++;
        if (count !== 3'd4) begin
            n_err++;
            $display("FAIL order_fill_count got %0d want 4", count);
        end
        enc_v = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_code !== want[i] || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL order_drain[%0d] got v=%0d code=%0d want v=1 code=%0d",
                         i, out_valid, out_code, want[i]);
            end
            tick();
        end
        n_vec++;
        if ({out_valid, count, out_code} !== 6'd0) begin
            n_err++;
            $display("FAIL order_empty got v=%0d cnt=%0d code=%0d want 0 0 0",
                     out_valid, count, out_code);
        end
    endtask

    task automatic test_overflow();
        fill_3102();
        enc_y = 2'd1;
        tick();
        n_vec++;
        if ({count, overflow, out_code} !== {3'd4, 1'b1, 2'd3}) begin
            n_err++;
            $display("FAIL ovf_drop got cnt=%0d ovf=%0d head=%0d want cnt=4 ovf=1 head=3",
                     count, overflow, out_code);
        end
        enc_v = 1'b0; clr_ovf = 1'b1;
        tick();
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear got %0d want 0", overflow);
        end
        enc_v = 1'b1; enc_y = 2'd3;
        tick();
        clr_ovf = 1'b0;
        n_vec++;
        if ({count, overflow} !== {3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_drop_beats_clear got cnt=%0d ovf=%0d want cnt=4 ovf=1",
                     count, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [1:0] want [4] = '{2'd1, 2'd0, 2'd2, 2'd1};
        fill_3102();
        enc_y = 2'd1; out_ready = 1'b1;
        tick();
        n_vec++;
        if ({count, overflow, out_code} !== {3'd4, 1'b0, 2'd1}) begin
            n_err++;
            $display("FAIL full_push_pop got cnt=%0d ovf=%0d head=%0d want cnt=4 ovf=0 head=1",
                     count, overflow, out_code);
        end
        enc_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_code !== want[i]) begin
                n_err++;
                $display("FAIL full_push_pop_drain[%0d] got %0d want %0d", i, out_code, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_midway();
        apply_reset();
        enc_v = 1'b1; enc_y = 2'd1; tick();
        enc_y = 2'd2; tick();
        n_vec++;
        if (count !== 3'd2) begin
            n_err++;
            $display("FAIL midreset_pre got cnt=%0d want 2", count);
        end
        rst = 1'b1; enc_y = 2'd3; out_ready = 1'b1;
        tick();
        n_vec++;
        if (act !== 7'd0) begin
            n_err++;
            $display("FAIL midreset_state got %b want %b", act, 7'd0);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({out_valid, count, out_code} !== {1'b1, 3'd1, 2'd3}) begin
            n_err++;
            $display("FAIL first_edge_event got v=%0d cnt=%0d code=%0d want v=1 cnt=1 code=3",
                     out_valid, count, out_code);
        end
    endtask

`ifdef EVENT_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [7:0] want [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
        apply_reset();
        enc_v = 1'b1; enc_y = 2'd0;
        tick(); tick(); tick();
        enc_y = 2'd1; tick();
        enc_v = 1'b0;
        n_vec++;
        if (out_ts !== 8'd0) begin
            n_err++;
            $display("FAIL ts_first got %0d want 0", out_ts);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_vec++;
        if (out_ts !== 8'd3) begin
            n_err++;
            $display("FAIL ts_gap got %0d want 3", out_ts);
        end
        apply_reset();
        for (int i = 0; i < 254; i++) tick();
        enc_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enc_y = 2'(i);
            tick();
        end
        enc_v = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_ts !== want[i]) begin
                n_err++;
                $display("FAIL ts_wrap[%0d] got %0d want %0d", i, out_ts, want[i]);
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            enc_v     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) enc_y = 2'($urandom_range(0, 3));
            out_ready = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            tick();
            n_vec++;
            if (act !== exp_state()) begin
                n_err++;
                $display("FAIL random[%0d] got v/cnt/code/ovf=%b want %b", i, act, exp_state());
            end
`ifdef EVENT_TIMESTAMP_EN
            n_vec++;
            if (out_ts !== ((mts.size() != 0) ? mts[0] : 8'd0)) begin
                n_err++;
                $display("FAIL random_ts[%0d] got %0d want %0d", i, out_ts,
                         (mts.size() != 0) ? mts[0] : 8'd0);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_reset_midway();
`ifdef EVENT_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_priority_event_queue
`default_nettype wire
